// File: rtl/mips_run_ctrl.sv
// Run controller for one program execution on the pipe_MIPS32 core:
// loads a memory image, holds the core in reset for a short clear window,
// lets it run until HLT or the cycle budget, then streams out a window of
// register-file contents.
module mips_run_ctrl #(
  parameter int ADDR_W       = 10,
  parameter int MAX_CYCLES   = 4096,
  parameter int CLEAR_CYCLES = 2,
  parameter int DUMP_REGS    = 6
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_rst,
  input  logic              core_halted,
  output logic [4:0]        rf_raddr,
  input  logic [31:0]       rf_rdata,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [4:0]        dump_idx,
  output logic [31:0]       dump_data,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              load_ovf,
  output logic [15:0]       cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_RUN,
    S_DUMP,
    S_DONE
  } state_t;

  // Last memory word; accepting it without ld_last means the image overflowed.
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  // Value of cycle_count in the final budgeted RUN cycle.
  localparam logic [15:0] BUDGET_LAST = 16'(MAX_CYCLES - 1);
  // Index of the final register in the dump window.
  localparam logic [4:0] LAST_IDX = 5'(DUMP_REGS - 1);
  localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
  logic [CLR_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic [15:0]       cycle_count_q, cycle_count_d;
  logic              timeout_q, timeout_d;
  logic              load_ovf_q, load_ovf_d;
  logic [4:0]        dump_idx_q, dump_idx_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  // State register and datapath flops; reset drops any pending write pulse.
  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q       <= S_IDLE;
      word_cnt_q    <= '0;
      clr_cnt_q     <= '0;
      cycle_count_q <= '0;
      timeout_q     <= 1'b0;
      load_ovf_q    <= 1'b0;
      dump_idx_q    <= '0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      word_cnt_q    <= word_cnt_d;
      clr_cnt_q     <= clr_cnt_d;
      cycle_count_q <= cycle_count_d;
      timeout_q     <= timeout_d;
      load_ovf_q    <= load_ovf_d;
      dump_idx_q    <= dump_idx_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  // Next-state and datapath updates for the load/clear/run/dump sequence.
  always_comb begin
    state_d       = state_q;
    word_cnt_d    = word_cnt_q;
    clr_cnt_d     = clr_cnt_q;
    cycle_count_d = cycle_count_q;
    timeout_d     = timeout_q;
    load_ovf_d    = load_ovf_q;
    dump_idx_d    = dump_idx_q;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d       = S_LOAD;
          word_cnt_d    = '0;
          timeout_d     = 1'b0;
          load_ovf_d    = 1'b0;
          cycle_count_d = '0;
          dump_idx_d    = '0;
        end
      end

      S_LOAD: begin
        clr_cnt_d = '0;
        if (ld_valid) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = word_cnt_q;
          mem_wdata_d = ld_data;
          word_cnt_d  = word_cnt_q + 1'b1;
          if (ld_last) begin
            state_d = S_CLEAR;
          end else if (word_cnt_q == LAST_ADDR) begin
            load_ovf_d = 1'b1;
            state_d    = S_CLEAR;
          end
        end
      end

      S_CLEAR: begin
        if (clr_cnt_q == CLR_LAST) begin
          state_d = S_RUN;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end

      S_RUN: begin
        if (cycle_count_q != 16'hFFFF) begin
          cycle_count_d = cycle_count_q + 16'd1;
        end
        if (core_halted) begin
          state_d = S_DUMP;
        end else if (cycle_count_q == BUDGET_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_DUMP;
        end
      end

      S_DUMP: begin
        if (dump_ready) begin
          if (dump_idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            dump_idx_d = dump_idx_q + 5'd1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State-decoded handshake and status outputs; the core is held in reset
  // until the image is loaded and the clear window has elapsed.
  always_comb begin
    ld_ready   = 1'b0;
    core_rst   = 1'b0;
    dump_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      S_IDLE: begin
        core_rst = 1'b1;
      end
      S_LOAD: begin
        ld_ready = 1'b1;
        core_rst = 1'b1;
        busy     = 1'b1;
      end
      S_CLEAR: begin
        core_rst = 1'b1;
        busy     = 1'b1;
      end
      S_RUN: begin
        busy = 1'b1;
      end
      S_DUMP: begin
        dump_valid = 1'b1;
        busy       = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        core_rst = 1'b1;
      end
    endcase
  end

  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign rf_raddr    = dump_idx_q;
  assign dump_idx    = dump_idx_q;
  assign dump_data   = rf_rdata;
  assign timeout     = timeout_q;
  assign load_ovf    = load_ovf_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Self-checking bench for mips_run_ctrl: a small instruction-level core stub,
// a sequential reference interpreter, and scoreboard monitors.
module tb_mips_run_ctrl;

  localparam int AW   = 10;
  localparam int MAXC = 64;
  localparam int SAW  = 3;

  logic clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  logic          rst, start, ld_valid, ld_ready, ld_last, mem_we, core_rst, core_halted;
  logic [31:0]   ld_data, mem_wdata, rf_rdata, dump_data;
  logic [AW-1:0] mem_addr;
  logic [4:0]    rf_raddr, dump_idx;
  logic          dump_valid, dump_ready, busy, done, timeout, load_ovf;
  logic [15:0]   cycle_count;

  logic           s_start, s_ld_valid, s_ld_ready, s_ld_last, s_mem_we, s_core_rst, s_core_halted;
  logic [31:0]    s_ld_data, s_mem_wdata, s_rf_rdata, s_dump_data;
  logic [SAW-1:0] s_mem_addr;
  logic [4:0]     s_rf_raddr, s_dump_idx;
  logic           s_dump_valid, s_dump_ready, s_busy, s_done, s_timeout, s_load_ovf;
  logic [15:0]    s_cycle_count;

  mips_run_ctrl #(.ADDR_W(AW), .MAX_CYCLES(MAXC), .CLEAR_CYCLES(2), .DUMP_REGS(6)) dut (
    .clk1(clk1), .rst(rst), .start(start), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_last(ld_last), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .core_rst(core_rst), .core_halted(core_halted),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data), .busy(busy),
    .done(done), .timeout(timeout), .load_ovf(load_ovf), .cycle_count(cycle_count)
  );

  mips_run_ctrl #(.ADDR_W(SAW), .MAX_CYCLES(MAXC), .CLEAR_CYCLES(2), .DUMP_REGS(6)) dut_small (
    .clk1(clk1), .rst(rst), .start(s_start), .ld_valid(s_ld_valid), .ld_ready(s_ld_ready),
    .ld_data(s_ld_data), .ld_last(s_ld_last), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
    .mem_wdata(s_mem_wdata), .core_rst(s_core_rst), .core_halted(s_core_halted),
    .rf_raddr(s_rf_raddr), .rf_rdata(s_rf_rdata), .dump_valid(s_dump_valid),
    .dump_ready(s_dump_ready), .dump_idx(s_dump_idx), .dump_data(s_dump_data), .busy(s_busy),
    .done(s_done), .timeout(s_timeout), .load_ovf(s_load_ovf), .cycle_count(s_cycle_count)
  );

  // Scoreboard state
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    int            cyc;
  } mem_exp_t;

  mem_exp_t    exp_mem[$];
  logic [34:0] s_exp_mem[$];
  logic [36:0] exp_dump[$];
  logic [17:0] exp_stat[$];
  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  logic [31:0] prog [0:127];

  always @(posedge clk1) cyc <= cyc + 1;

  function automatic void checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  // Core stub: word memory fed by the write port, one instruction per cycle
  // while out of reset (ADD/SUB/OR/ADDI/HLT), HALTED registered after HLT.
  logic [31:0] cmem [0:(1<<AW)-1];
  logic [31:0] cregs [0:31];
  logic [AW-1:0] cpc;
  logic chalt, clr_mem;
  logic [31:0] c_ins;
  logic [4:0]  c_rs, c_rt, c_rd;
  assign c_ins = cmem[cpc];
  assign c_rs = c_ins[25:21];
  assign c_rt = c_ins[20:16];
  assign c_rd = c_ins[15:11];
  assign core_halted = chalt;
  assign rf_rdata = cregs[rf_raddr];

  always @(posedge clk1) begin
    if (clr_mem) begin
      for (int i = 0; i < (1<<AW); i++) cmem[i] <= 32'h0;
      for (int i = 0; i < 32; i++) cregs[i] <= 32'h0;
    end else begin
      if (mem_we) cmem[mem_addr] <= mem_wdata;
      if (!core_rst && !chalt) begin
        case (c_ins[31:26])
          6'h00: cregs[c_rd] <= cregs[c_rs] + cregs[c_rt];
          6'h01: cregs[c_rd] <= cregs[c_rs] - cregs[c_rt];
          6'h03: cregs[c_rd] <= cregs[c_rs] | cregs[c_rt];
          6'h0A: cregs[c_rt] <= cregs[c_rs] + {{16{c_ins[15]}}, c_ins[15:0]};
          default: ;
        endcase
      end
    end
    if (core_rst) begin
      cpc   <= '0;
      chalt <= 1'b0;
    end else if (!chalt) begin
      cpc <= cpc + 1'b1;
      if (c_ins[31:26] == 6'h3F) chalt <= 1'b1;
    end
  end

  // Reference: interpret the image in order, find HLT, derive the halt/budget
  // outcome and the register window the dump must show.
  task automatic pushExpected(input int n);
    logic [31:0] r [0:31];
    logic [31:0] w;
    int h, cnt;
    bit tmo;
    for (int i = 0; i < 32; i++) r[i] = 32'h0;
    h = -1;
    for (int pc = 0; pc < n; pc++) begin
      w = prog[pc];
      if (w[31:26] == 6'h3F) begin
        h = pc;
        break;
      end
      case (w[31:26])
        6'h00: r[w[15:11]] = r[w[25:21]] + r[w[20:16]];
        6'h01: r[w[15:11]] = r[w[25:21]] - r[w[20:16]];
        6'h03: r[w[15:11]] = r[w[25:21]] | r[w[20:16]];
        6'h0A: r[w[20:16]] = r[w[25:21]] + {{16{w[15]}}, w[15:0]};
        default: ;
      endcase
    end
    // HALTED becomes visible the cycle after HLT executes; halt wins if it is
    // seen no later than the last budgeted cycle.
    if (h >= 0 && h + 1 <= MAXC - 1) begin
      cnt = h + 2;
      tmo = 1'b0;
    end else begin
      cnt = MAXC;
      tmo = 1'b1;
    end
    for (int i = 0; i < 6; i++) exp_dump.push_back({5'(i), r[i]});
    exp_stat.push_back({16'(cnt), tmo, 1'b0});
  endtask

  task automatic genProgram(input int n, input int hlt_pos);
    int k, rs, rt, rd;
    for (int i = 0; i < n; i++) begin
      k  = $urandom_range(0, 3);
      rs = $urandom_range(0, 5);
      rt = $urandom_range(1, 5);
      rd = $urandom_range(1, 5);
      case (k)
        0: prog[i] = {6'h0A, 5'(rs), 5'(rt), 16'($urandom)};
        1: prog[i] = {6'h00, 5'(rs), 5'(rt), 5'(rd), 11'h0};
        2: prog[i] = {6'h01, 5'(rs), 5'(rt), 5'(rd), 11'h0};
        default: prog[i] = {6'h03, 5'(rs), 5'(rt), 5'(rd), 11'h0};
      endcase
      if (i == hlt_pos) prog[i] = 32'hFC000000;
    end
  endtask

  task automatic loadDirected();
    logic [31:0] d [0:8];
    d = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
          32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};
    for (int i = 0; i < 9; i++) prog[i] = d[i];
  endtask

  task automatic loadImage(input int n, input bit gaps);
    int i = 0;
    for (int c = 0; c < 4 * n + 40 && i < n; c++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        ld_valid = 1'b0;
        @(posedge clk1); #1;
      end else begin
        ld_valid = 1'b1;
        ld_data  = prog[i];
        ld_last  = (i == n - 1);
        @(negedge clk1);
        if (ld_ready) begin
          exp_mem.push_back('{addr: AW'(i), data: prog[i], cyc: cyc + 1});
          i++;
        end
        @(posedge clk1); #1;
      end
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    if (i < n) checkOutput("load_words_accepted", 64'(i), 64'(n));
  endtask

  task automatic waitDone(input int mode);
    int stall_cnt = 0;
    bit fin = 1'b0;
    for (int c = 0; c < 600 && !fin; c++) begin
      @(posedge clk1); #1;
      start = 1'b0;
      case (mode)
        1: begin
          if (dump_valid && dump_idx == 5'd2 && stall_cnt < 5) begin
            dump_ready = 1'b0;
            stall_cnt++;
          end else dump_ready = 1'b1;
        end
        2: begin
          dump_ready = 1'($urandom_range(0, 1));
          start = busy && ($urandom_range(0, 3) == 0);
        end
        default: dump_ready = 1'b1;
      endcase
      @(negedge clk1);
      if (done) fin = 1'b1;
    end
    start = 1'b0;
    dump_ready = 1'b1;
    if (!fin) checkOutput("done_reached", 64'(0), 64'(1));
  endtask

  // One complete run of prog[0..n-1]; mode 3 aborts with rst at RUN cycle 7.
  task automatic applyStimulus(input int n, input bit gaps, input int mode);
    bit hit = 1'b0;
    @(posedge clk1); #1;
    clr_mem = 1'b1;
    @(posedge clk1); #1;
    clr_mem = 1'b0;
    pushExpected(n);
    start = 1'b1;
    @(posedge clk1); #1;
    start = 1'b0;
    loadImage(n, gaps);
    @(negedge clk1);
    checkOutput("clear_cycle1", 64'({core_rst, ld_ready, busy}), 64'(3'b101));
    @(negedge clk1);
    checkOutput("clear_cycle2", 64'({core_rst, ld_ready, busy}), 64'(3'b101));
    @(negedge clk1);
    checkOutput("run_entry", 64'({core_rst, busy}), 64'(2'b01));
    if (mode == 3) begin
      for (int c = 0; c < 200 && !hit; c++) begin
        if (!core_rst && cycle_count == 16'd7) hit = 1'b1;
        else @(negedge clk1);
      end
      if (!hit) checkOutput("abort_reach_cycle7", 64'(0), 64'(1));
      rst = 1'b1;
      @(negedge clk1);
      checkOutput("abort_ctrl", 64'({core_rst, busy, done, ld_ready, dump_valid, mem_we, timeout}),
                  64'(7'b1000000));
      checkOutput("abort_count", 64'(cycle_count), 64'(0));
      rst = 1'b0;
      exp_dump.delete();
      exp_stat.delete();
    end else begin
      waitDone(mode);
    end
  endtask

  // Monitors: memory writes, dump handshakes, dump hold under backpressure,
  // and final status when done rises.
  initial begin
    logic stall_prev = 1'b0;
    logic done_prev = 1'b0;
    logic [4:0] prev_idx = '0;
    logic [31:0] prev_data = '0;
    mem_exp_t e;
    logic [36:0] ed;
    logic [34:0] es;
    logic [17:0] st;
    forever begin
      @(negedge clk1);
      if (rst) begin
        stall_prev = 1'b0;
        done_prev  = 1'b0;
      end else begin
        if (mem_we) begin
          if (exp_mem.size() == 0) checkOutput("mem_write_unexpected", 64'(1), 64'(0));
          else begin
            e = exp_mem.pop_front();
            checkOutput("mem_write", 64'({mem_addr, mem_wdata}), 64'({e.addr, e.data}));
            checkOutput("mem_write_latency", 64'(cyc), 64'(e.cyc));
          end
        end
        if (s_mem_we) begin
          if (s_exp_mem.size() == 0) checkOutput("small_mem_write_unexpected", 64'(1), 64'(0));
          else begin
            es = s_exp_mem.pop_front();
            checkOutput("small_mem_write", 64'({s_mem_addr, s_mem_wdata}), 64'(es));
          end
        end
        if (stall_prev)
          checkOutput("dump_hold", 64'({dump_valid, dump_idx, dump_data}),
                      64'({1'b1, prev_idx, prev_data}));
        if (dump_valid && dump_ready) begin
          if (exp_dump.size() == 0) checkOutput("dump_extra_word", 64'(1), 64'(0));
          else begin
            ed = exp_dump.pop_front();
            checkOutput("dump_word", 64'({dump_idx, dump_data}), 64'(ed));
          end
        end
        stall_prev = dump_valid && !dump_ready;
        prev_idx   = dump_idx;
        prev_data  = dump_data;
        if (done && !done_prev) begin
          checkOutput("done_not_busy", 64'(busy), 64'(0));
          checkOutput("dump_all_words", 64'(exp_dump.size()), 64'(0));
          if (exp_stat.size() == 0) checkOutput("status_unexpected", 64'(1), 64'(0));
          else begin
            st = exp_stat.pop_front();
            checkOutput("run_status", 64'({cycle_count, timeout, load_ovf}), 64'(st));
          end
        end
        done_prev = done;
      end
    end
  end

  initial begin
    int acc, n, h;
    bit fin;
    rst = 1'b1; start = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    dump_ready = 1'b1; clr_mem = 1'b0;
    s_start = 1'b0; s_ld_valid = 1'b0; s_ld_data = '0; s_ld_last = 1'b0;
    s_core_halted = 1'b0; s_rf_rdata = 32'h0; s_dump_ready = 1'b1;
    repeat (3) @(posedge clk1);
    #1 rst = 1'b0;
    @(negedge clk1);
    checkOutput("reset_ctrl", 64'({core_rst, ld_ready, mem_we, dump_valid, busy, done, timeout, load_ovf}),
                64'(8'b10000000));
    checkOutput("reset_mem_port", 64'({mem_addr, mem_wdata}), 64'(0));
    checkOutput("reset_count_idx", 64'({cycle_count, dump_idx}), 64'(0));
    checkOutput("reset_small_ctrl", 64'({s_core_rst, s_ld_ready, s_busy, s_done, s_load_ovf}),
                64'(5'b10000));

    $display("[TB] directed program, halt and full dump");
    loadDirected();
    applyStimulus(9, 1'b0, 0);

    $display("[TB] reset during RUN, then rerun");
    loadDirected();
    applyStimulus(9, 1'b0, 3);
    loadDirected();
    applyStimulus(9, 1'b0, 0);

    $display("[TB] dump backpressure");
    loadDirected();
    applyStimulus(9, 1'b0, 1);

    $display("[TB] timeout and halt/budget boundary");
    genProgram(20, -1);
    applyStimulus(20, 1'b0, 0);
    genProgram(63, 62);
    applyStimulus(63, 1'b0, 0);
    genProgram(64, 63);
    applyStimulus(64, 1'b0, 0);

    $display("[TB] randomized runs");
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 40);
      h = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, n - 1));
      genProgram(n, h);
      applyStimulus(n, 1'b1, 2);
    end

    $display("[TB] load overflow on small memory");
    @(posedge clk1); #1;
    s_start = 1'b1;
    @(posedge clk1); #1;
    s_start = 1'b0;
    acc = 0;
    s_ld_valid = 1'b1;
    for (int c = 0; c < 40 && acc < 8; c++) begin
      s_ld_data = 32'hA5000000 + 32'(acc);
      @(negedge clk1);
      if (s_ld_ready) begin
        s_exp_mem.push_back({3'(acc), s_ld_data});
        acc++;
      end
      @(posedge clk1); #1;
    end
    s_ld_data = 32'hA5000008;
    @(negedge clk1);
    checkOutput("ovf_after_8th", 64'({s_load_ovf, s_ld_ready, s_busy, s_core_rst}), 64'(4'b1011));
    for (int c = 0; c < 4; c++) begin
      @(negedge clk1);
      if (s_ld_ready) acc++;
    end
    @(posedge clk1); #1;
    s_ld_valid = 1'b0;
    checkOutput("ovf_words_accepted", 64'(acc), 64'(8));
    fin = 1'b0;
    for (int c = 0; c < 300 && !fin; c++) begin
      @(negedge clk1);
      if (s_done) fin = 1'b1;
    end
    checkOutput("small_status", 64'({s_done, s_cycle_count, s_timeout, s_load_ovf}),
                64'({1'b1, 16'(MAXC), 1'b1, 1'b1}));
    checkOutput("small_writes_drained", 64'(s_exp_mem.size()), 64'(0));

    repeat (3) @(negedge clk1);
    checkOutput("queues_drained", 64'(exp_mem.size() + exp_dump.size() + exp_stat.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
